// File: rtl/gray_step_arbiter.sv
// Two-requester round-robin step arbiter driving a shared Gray-coded position counter.
// Optional build macro GRAY_ARB_SAT_EN turns the modulo counter into a saturating one.
module gray_step_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_i,
    input  logic             dir0_i,
    input  logic             req1_i,
    input  logic             dir1_i,
    output logic             ack0_o,
    output logic             ack1_o,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] bin_o,
    output logic             wrap_o
);

    typedef enum logic [1:0] {IDLE, ACK0, ACK1} state_t;

    state_t             state_q;
    logic               last_q;
    logic [WIDTH-1:0]   bin_q;
    logic [WIDTH-1:0]   count_q;
    logic               ack0_q, ack1_q, wrap_q;

    logic               elig0, elig1, gnt0, gnt1, dir_sel, at_edge;
    logic [WIDTH-1:0]   bin_d;

    // A requester is ignored while its own ack is out: that level is the stale request.
    always_comb begin
        elig0   = req0_i && (state_q != ACK0);
        elig1   = req1_i && (state_q != ACK1);
        gnt0    = elig0 && (!elig1 || last_q);
        gnt1    = elig1 && !gnt0;
        dir_sel = gnt0 ? dir0_i : dir1_i;
        at_edge = dir_sel ? (&bin_q) : ~(|bin_q);
        bin_d   = bin_q;
        if (gnt0 || gnt1) begin
            bin_d = dir_sel ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
`ifdef GRAY_ARB_SAT_EN
            if (at_edge) bin_d = bin_q;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            bin_q   <= '0;
            count_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            count_q <= bin_d ^ (bin_d >> 1);
            ack0_q  <= gnt0;
            ack1_q  <= gnt1;
            wrap_q  <= (gnt0 || gnt1) && at_edge;
            if (gnt0) begin
                state_q <= ACK0;
                last_q  <= 1'b0;
            end else if (gnt1) begin
                state_q <= ACK1;
                last_q  <= 1'b1;
            end else begin
                state_q <= IDLE;
            end
        end
    end

    assign ack0_o  = ack0_q;
    assign ack1_o  = ack1_q;
    assign bin_o   = bin_q;
    assign count_o = count_q;
    assign wrap_o  = wrap_q;

endmodule
